// File: rtl/div_arbiter.sv
// Two-port front end for a shared iterative divider.
// Picks one of two requesters round-robin, latches its operands, runs the
// divider through its enable/hold handshake and returns the quotient or the
// remainder on a valid/ready response channel. A one-entry cache of the last
// completed (a, b, signed) result lets a DIV/REM pair on the same operands
// finish with a single divider run.
`timescale 1ns / 1ps

module div_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  // Request channel, one lane per requester
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [2*N-1:0] req_a_i,
  input  logic [2*N-1:0] req_b_i,
  input  logic [1:0]     req_signed_i,
  input  logic [1:0]     req_rem_i,
  // Response channel, data shared by both requesters
  output logic [1:0]     rsp_valid_o,
  output logic [N-1:0]   rsp_data_o,
  input  logic [1:0]     rsp_ready_i,
  // Drop outstanding work and forget the cached result
  input  logic           flush_i,
  // Divider interface
  output logic [N-1:0]   div_first_operand_o,
  output logic [N-1:0]   div_second_operand_o,
  output logic           div_signed_o,
  output logic           div_enable_o,
  input  logic           div_hold_i,
  input  logic [N-1:0]   div_result_i,
  input  logic [N-1:0]   rem_result_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    ISSUE = 2'd1,  // divider running, enable high
    RESP  = 2'd2,  // response presented to the granted requester
    DRAIN = 2'd3   // flushed while running; let the divider finish quietly
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic           first_q, first_d;      // first ISSUE cycle, hold not yet meaningful
  logic           prio_q, prio_d;        // requester favoured on a tie
  logic           gid_q, gid_d;          // requester owning the current operation

  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           sgn_q, sgn_d;
  logic           rem_q, rem_d;
  logic [N-1:0]   data_q, data_d;

  logic           cache_valid_q, cache_valid_d;
  logic [N-1:0]   cache_a_q, cache_a_d;
  logic [N-1:0]   cache_b_q, cache_b_d;
  logic           cache_sgn_q, cache_sgn_d;
  logic [N-1:0]   cache_quo_q, cache_quo_d;
  logic [N-1:0]   cache_rem_q, cache_rem_d;

  // ---------------------------------------------------------------------------
  // Request selection
  // ---------------------------------------------------------------------------
  logic           grant_id;
  logic           accept;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_sgn;
  logic           sel_rem;
  logic           cache_hit;
  logic           div_done;

  // Pick the granted lane: a lone requester wins, a tie goes to the favoured one.
  always_comb begin
    // NOTE: every signal written in an always_comb is given a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    grant_id = 1'b0;
    case (req_valid_i)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = prio_q;
      default: grant_id = 1'b0;
    endcase
  end

  // A request is taken only while idle and never during a flush.
  assign accept  = (state_q == IDLE) && !flush_i && (|req_valid_i);

  assign sel_a   = grant_id ? req_a_i[2*N-1:N] : req_a_i[N-1:0];
  assign sel_b   = grant_id ? req_b_i[2*N-1:N] : req_b_i[N-1:0];
  assign sel_sgn = grant_id ? req_signed_i[1]  : req_signed_i[0];
  assign sel_rem = grant_id ? req_rem_i[1]     : req_rem_i[0];

  // The cache holds both results, so the rem flag is not part of the tag.
  assign cache_hit = cache_valid_q
                  && (sel_a   == cache_a_q)
                  && (sel_b   == cache_b_q)
                  && (sel_sgn == cache_sgn_q);

  // Divider finished: hold is low and we are past the cycle where start is
  // still propagating combinationally through the divider.
  assign div_done = (state_q == ISSUE) && !first_q && !div_hold_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Sequence IDLE -> ISSUE/RESP -> IDLE, diverting to DRAIN on a mid-run flush.
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = cache_hit ? RESP : ISSUE;
          first_d = !cache_hit;
        end
      end
      ISSUE: begin
        // A flush landing on the completion cycle still wins: nothing is
        // left running, so go straight home without a response.
        if (flush_i) begin
          state_d = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i[gid_q]) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // The divider cannot be aborted and freezes if enable drops mid-run,
        // so keep it enabled until it reports completion.
        if (!div_hold_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request's fields and move the round-robin pointer.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    rem_d  = rem_q;
    gid_d  = gid_q;
    prio_d = prio_q;
    if (accept) begin
      a_d    = sel_a;
      b_d    = sel_b;
      sgn_d  = sel_sgn;
      rem_d  = sel_rem;
      gid_d  = grant_id;
      prio_d = ~grant_id;
    end
  end

  // Response data comes from the cache on a hit or the divider on completion.
  always_comb begin
    data_d = data_q;
    if (accept && cache_hit) begin
      data_d = sel_rem ? cache_rem_q : cache_quo_q;
    end else if (div_done && !flush_i) begin
      data_d = rem_q ? rem_result_i : div_result_i;
    end
  end

  // Refill the cache on a clean completion; any flush invalidates it.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_sgn_d   = cache_sgn_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
    if (div_done && !flush_i) begin
      cache_valid_d = 1'b1;
      cache_a_d     = a_q;
      cache_b_d     = b_q;
      cache_sgn_d   = sgn_q;
      cache_quo_d   = div_result_i;
      cache_rem_d   = rem_result_i;
    end
    if (flush_i) begin
      cache_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state: FSM, first-cycle flag, arbitration pointer and owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      first_q <= first_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
    end
  end

  // Operand and response-data registers feeding the divider and requesters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      rem_q  <= 1'b0;
      data_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sgn_q  <= sgn_d;
      rem_q  <= rem_d;
      data_q <= data_d;
    end
  end

  // One-entry result cache.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the cache payload is reset together with its valid bit. Valid
      // alone would be enough for correctness, but a defined payload keeps
      // the tag compare and response mux free of X after reset.
      cache_valid_q <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_sgn_q   <= 1'b0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_sgn_q   <= cache_sgn_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready_o          = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid_o          = (state_q == RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data_o           = data_q;

  // Operands come straight from registers so they stay stable for a whole run.
  assign div_first_operand_o  = a_q;
  assign div_second_operand_o = b_q;
  assign div_signed_o         = sgn_q;
  assign div_enable_o         = (state_q == ISSUE) || (state_q == DRAIN);

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a behavioural divider with the enable/hold protocol
// sits on the divider port, and a reference model of arbitration, result
// cache and response latency checks every transaction.
`timescale 1ns / 1ps

module tb_div_arbiter;

  localparam int N = 32;
  localparam logic [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ONES  = '1;

  logic           clk;
  logic           reset_n;
  logic [1:0]     req_valid_i;
  logic [1:0]     req_ready_o;
  logic [2*N-1:0] req_a_i;
  logic [2*N-1:0] req_b_i;
  logic [1:0]     req_signed_i;
  logic [1:0]     req_rem_i;
  logic [1:0]     rsp_valid_o;
  logic [N-1:0]   rsp_data_o;
  logic [1:0]     rsp_ready_i;
  logic           flush_i;
  logic [N-1:0]   div_first_operand_o;
  logic [N-1:0]   div_second_operand_o;
  logic           div_signed_o;
  logic           div_enable_o;
  logic           div_hold_i;
  logic [N-1:0]   div_result_i;
  logic [N-1:0]   rem_result_i;

  div_arbiter #(.N(N)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_a_i              (req_a_i),
    .req_b_i              (req_b_i),
    .req_signed_i         (req_signed_i),
    .req_rem_i            (req_rem_i),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_data_o           (rsp_data_o),
    .rsp_ready_i          (rsp_ready_i),
    .flush_i              (flush_i),
    .div_first_operand_o  (div_first_operand_o),
    .div_second_operand_o (div_second_operand_o),
    .div_signed_o         (div_signed_o),
    .div_enable_o         (div_enable_o),
    .div_hold_i           (div_hold_i),
    .div_result_i         (div_result_i),
    .rem_result_i         (rem_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Arithmetic reference (RISC-V style division semantics)
  // ---------------------------------------------------------------------------
  function automatic logic [N-1:0] ref_quo(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
    logic signed [N-1:0] sa, sb, sq;
    if (b == '0) return ONES;
    if (s) begin
      if (a == MIN_S && b == ONES) return MIN_S;
      sa = a;
      sb = b;
      sq = sa / sb;
      return sq;
    end
    return a / b;
  endfunction

  function automatic logic [N-1:0] ref_rem(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
    logic signed [N-1:0] sa, sb, sr;
    if (b == '0) return a;
    if (s) begin
      if (a == MIN_S && b == ONES) return '0;
      sa = a;
      sb = b;
      sr = sa % sb;
      return sr;
    end
    return a % b;
  endfunction

  function automatic bit is_fast(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    return (b == '0) || (b == ONE) || (s && a == MIN_S && b == ONES);
  endfunction

  // ---------------------------------------------------------------------------
  // Divider stand-in: hold is high for N+3 enabled cycles (1 on the fast path),
  // results are valid once hold drops, and dropping enable restarts it.
  // ---------------------------------------------------------------------------
  int unsigned dm_cnt;
  int unsigned dm_len;

  always_comb begin
    div_result_i = ref_quo(div_first_operand_o, div_second_operand_o, div_signed_o);
    rem_result_i = ref_rem(div_first_operand_o, div_second_operand_o, div_signed_o);
    dm_len       = is_fast(div_first_operand_o, div_second_operand_o, div_signed_o) ? 1 : N + 3;
    div_hold_i   = div_enable_o && (dm_cnt < dm_len);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          dm_cnt <= 0;
    else if (!div_enable_o) dm_cnt <= 0;
    else if (div_hold_i)   dm_cnt <= dm_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Pending requests and reference cache
  // ---------------------------------------------------------------------------
  logic         pv[2];
  logic [N-1:0] pa[2];
  logic [N-1:0] pb[2];
  logic         ps[2];
  logic         pr[2];

  logic         m_cv;
  logic [N-1:0] m_ca, m_cb;
  logic         m_cs;
  logic [N-1:0] last_data;

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid_i[i]        = pv[i];
      req_a_i[i*N +: N]     = pa[i];
      req_b_i[i*N +: N]     = pb[i];
      req_signed_i[i]       = ps[i];
      req_rem_i[i]          = pr[i];
    end
  endtask

  task automatic set_req(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s, input logic r);
    pv[k] = 1'b1;
    pa[k] = a;
    pb[k] = b;
    ps[k] = s;
    pr[k] = r;
  endtask

  // Fresh operands that always take the full-length divide.
  task automatic new_ops(input int k);
    set_req(k, $urandom, N'($urandom_range(2, 5000)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    pv[0]       = 1'b0;
    pv[1]       = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 2'b00;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #2;
    m_cv = 1'b0;
  endtask

  // Wait (bounded) for a request to be accepted; checks which lane got it.
  task automatic accept_req(input int exp_k, output int k, output bit ok);
    int w;
    logic [1:0] exp_oh;
    exp_oh = (exp_k == 1) ? 2'b10 : 2'b01;
    drive_reqs();
    #1;
    w = 0;
    while (req_ready_o === 2'b00 && w < 50) begin
      @(posedge clk);
      #2;
      w++;
    end
    k  = 0;
    ok = 1'b0;
    total++;
    if (req_ready_o === 2'b00) begin
      bad++;
      $display("FAIL accept_timeout: req_ready_o=%b after %0d cycles, want %b", req_ready_o, w,
               exp_oh);
      return;
    end
    if (req_ready_o !== exp_oh) begin
      bad++;
      $display("FAIL grant: req_ready_o=%b want %b", req_ready_o, exp_oh);
    end
    k  = req_ready_o[1] ? 1 : 0;
    ok = 1'b1;
  endtask

  // Count cycles from accept until rsp_valid appears (bounded).
  task automatic wait_rsp(output int lat, output bit saw_en, output bit ok);
    lat    = 1;
    saw_en = 1'b0;
    while (rsp_valid_o === 2'b00 && lat < 200) begin
      if (div_enable_o === 1'b1) saw_en = 1'b1;
      @(posedge clk);
      #2;
      lat++;
    end
    ok = (rsp_valid_o !== 2'b00);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: no rsp_valid_o within %0d cycles", lat);
    end
  endtask

  // One full transaction: accept, latency, data, hold-until-ready, release.
  task automatic serve(input int exp_k, input bit refill);
    int k, lat, exp_lat, hold_n;
    bit ok, saw_en, hit;
    logic [N-1:0] ea, eb, exp_d;
    logic es, er;
    logic [1:0] oh;
    accept_req(exp_k, k, ok);
    if (!ok) return;
    ea      = pa[k];
    eb      = pb[k];
    es      = ps[k];
    er      = pr[k];
    hit     = m_cv && ea == m_ca && eb == m_cb && es == m_cs;
    exp_lat = hit ? 1 : (is_fast(ea, eb, es) ? 3 : N + 5);
    exp_d   = er ? ref_rem(ea, eb, es) : ref_quo(ea, eb, es);
    oh      = (k == 1) ? 2'b10 : 2'b01;
    @(posedge clk);
    #1;
    if (refill) new_ops(k);
    else pv[k] = 1'b0;
    drive_reqs();
    #1;
    wait_rsp(lat, saw_en, ok);
    if (!ok) return;
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL latency: got %0d want %0d (a=%h b=%h s=%0d hit=%0d)", lat, exp_lat, ea, eb,
               es, hit);
    end
    total++;
    if (rsp_valid_o !== oh) begin
      bad++;
      $display("FAIL rsp_valid: got %b want %b", rsp_valid_o, oh);
    end
    total++;
    if (rsp_data_o !== exp_d) begin
      bad++;
      $display("FAIL rsp_data: got %h want %h (a=%h b=%h s=%0d rem=%0d)", rsp_data_o, exp_d, ea,
               eb, es, er);
    end
    if (hit) begin
      total++;
      if (saw_en || div_enable_o !== 1'b0) begin
        bad++;
        $display("FAIL hit_enable: div_enable_o went high on a cache hit, want 0");
      end
    end
    last_data = rsp_data_o;
    if (!hit) begin
      m_cv = 1'b1;
      m_ca = ea;
      m_cb = eb;
      m_cs = es;
    end
    // The other requester's ready must not release this response.
    hold_n      = $urandom_range(0, 3);
    rsp_ready_i = ~oh;
    for (int i = 0; i < hold_n; i++) begin
      @(posedge clk);
      #2;
      total++;
      if (rsp_valid_o !== oh || rsp_data_o !== exp_d) begin
        bad++;
        $display("FAIL rsp_hold: valid=%b data=%h want valid=%b data=%h", rsp_valid_o,
                 rsp_data_o, oh, exp_d);
      end
    end
    rsp_ready_i = oh;
    @(posedge clk);
    #1 rsp_ready_i = 2'b00;
    #1;
    total++;
    if (rsp_valid_o !== 2'b00) begin
      bad++;
      $display("FAIL rsp_release: rsp_valid_o=%b want 00", rsp_valid_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n     = 1'b0;
    pv[0]       = 1'b0;
    pv[1]       = 1'b0;
    pa[0]       = '0;
    pa[1]       = '0;
    pb[0]       = '0;
    pb[1]       = '0;
    ps[0]       = 1'b0;
    ps[1]       = 1'b0;
    pr[0]       = 1'b0;
    pr[1]       = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 2'b00;
    drive_reqs();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (rsp_valid_o !== 2'b00 || req_ready_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_handshake: rsp_valid=%b req_ready=%b want 00/00", rsp_valid_o,
               req_ready_o);
    end
    total++;
    if (div_enable_o !== 1'b0 || div_signed_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_div_ctrl: enable=%b signed=%b want 0/0", div_enable_o, div_signed_o);
    end
    total++;
    if (div_first_operand_o !== '0 || div_second_operand_o !== '0 || rsp_data_o !== '0) begin
      bad++;
      $display("FAIL reset_data: op1=%h op2=%h rsp=%h want 0", div_first_operand_o,
               div_second_operand_o, rsp_data_o);
    end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #2;
    total++;
    if (rsp_valid_o !== 2'b00 || div_enable_o !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: rsp_valid=%b enable=%b want 00/0", rsp_valid_o,
               div_enable_o);
    end
    m_cv = 1'b0;
  endtask

  task automatic test_basic();
    set_req(0, 32'd100, 32'd7, 1'b0, 1'b0);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'd14) begin
      bad++;
      $display("FAIL basic_quo: got %0d want 14", last_data);
    end
    set_req(1, 32'd100, 32'd7, 1'b0, 1'b1);
    serve(1, 1'b0);
    total++;
    if (last_data !== 32'd2) begin
      bad++;
      $display("FAIL basic_rem_hit: got %0d want 2", last_data);
    end
  endtask

  task automatic test_signed();
    set_req(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL signed_quo: got %h want fffffffd", last_data);
    end
    set_req(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL signed_rem: got %h want ffffffff", last_data);
    end
  endtask

  task automatic test_fast_path();
    set_req(0, 32'd5, 32'd0, 1'b0, 1'b0);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div0_quo: got %h want ffffffff", last_data);
    end
    set_req(1, 32'd5, 32'd0, 1'b0, 1'b1);
    serve(1, 1'b0);
    total++;
    if (last_data !== 32'd5) begin
      bad++;
      $display("FAIL div0_rem: got %h want 5", last_data);
    end
    set_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'h8000_0000) begin
      bad++;
      $display("FAIL ovf_quo: got %h want 80000000", last_data);
    end
    set_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    serve(0, 1'b0);
    total++;
    if (last_data !== 32'd0) begin
      bad++;
      $display("FAIL ovf_rem: got %h want 0", last_data);
    end
    set_req(1, 32'd1234, 32'd1, 1'b0, 1'b0);
    serve(1, 1'b0);
  endtask

  // Both requesters valid every cycle: grants must alternate starting with 0.
  task automatic test_round_robin();
    do_reset();
    new_ops(0);
    new_ops(1);
    for (int i = 0; i < 4; i++) serve(i % 2, 1'b1);
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    drive_reqs();
  endtask

  task automatic test_flush_idle();
    set_req(0, 32'd77, 32'd5, 1'b0, 1'b0);
    serve(0, 1'b0);
    set_req(1, 32'd77, 32'd5, 1'b0, 1'b1);
    flush_i = 1'b1;
    drive_reqs();
    #1;
    total++;
    if (req_ready_o !== 2'b00) begin
      bad++;
      $display("FAIL flush_blocks_ready: req_ready_o=%b want 00", req_ready_o);
    end
    @(posedge clk);
    #2 flush_i = 1'b0;
    m_cv = 1'b0;
    serve(1, 1'b0);
  endtask

  // Flush a run `offset` cycles after accept: no response, enable held to the end.
  task automatic test_flush_issue(input int offset);
    int k, first_low;
    bit ok, saw_rsp;
    set_req(0, N'(1000 + offset), 32'd3, 1'b0, 1'b0);
    accept_req(0, k, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    pv[0] = 1'b0;
    drive_reqs();
    first_low = -1;
    saw_rsp   = 1'b0;
    for (int cyc = 1; cyc <= N + 12; cyc++) begin
      flush_i = (cyc == offset);
      #1;
      if (rsp_valid_o !== 2'b00) saw_rsp = 1'b1;
      if (div_enable_o !== 1'b1 && first_low < 0) first_low = cyc;
      @(posedge clk);
      #1;
    end
    flush_i = 1'b0;
    m_cv    = 1'b0;
    total++;
    if (first_low != N + 5) begin
      bad++;
      $display("FAIL drain_enable: enable first low at cycle %0d want %0d (flush at %0d)",
               first_low, N + 5, offset);
    end
    total++;
    if (saw_rsp) begin
      bad++;
      $display("FAIL flush_no_rsp: rsp_valid_o seen after flush at %0d, want none", offset);
    end
    set_req(0, N'(1000 + offset), 32'd3, 1'b0, 1'b0);
    serve(0, 1'b0);
  endtask

  task automatic test_flush_resp();
    int k, lat;
    bit ok, saw_en;
    set_req(0, 32'd9, 32'd1, 1'b0, 1'b0);
    accept_req(0, k, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    pv[0] = 1'b0;
    drive_reqs();
    #1;
    wait_rsp(lat, saw_en, ok);
    if (!ok) return;
    total++;
    if (lat != 3 || rsp_data_o !== 32'd9) begin
      bad++;
      $display("FAIL div1_fast: lat=%0d data=%h want 3/9", lat, rsp_data_o);
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    #1;
    total++;
    if (rsp_valid_o !== 2'b00) begin
      bad++;
      $display("FAIL flush_resp: rsp_valid_o=%b want 00", rsp_valid_o);
    end
    m_cv = 1'b0;
    set_req(0, 32'd9, 32'd1, 1'b0, 1'b1);
    serve(0, 1'b0);
  endtask

  task automatic test_random();
    int k, c;
    for (int i = 0; i < 24; i++) begin
      k     = $urandom_range(0, 1);
      c     = $urandom_range(0, 9);
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      if (c < 3 && m_cv) set_req(k, m_ca, m_cb, m_cs, 1'($urandom_range(0, 1)));
      else if (c == 3) set_req(k, $urandom, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (c == 4) set_req(k, $urandom, ONE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (c == 5) set_req(k, MIN_S, ONES, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (c == 6) set_req(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else new_ops(k);
      serve(k, 1'b0);
    end
  endtask

  // Reset in the middle of a run: everything drops at once, pointer back to 0.
  task automatic test_reset_mid();
    int k;
    bit ok;
    set_req(0, 32'd12345, 32'd17, 1'b0, 1'b0);
    accept_req(0, k, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    pv[0] = 1'b0;
    drive_reqs();
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({req_ready_o, rsp_valid_o, div_enable_o, div_signed_o} !== 6'b0 ||
        div_first_operand_o !== '0 || div_second_operand_o !== '0 || rsp_data_o !== '0) begin
      bad++;
      $display("FAIL reset_async: enable=%b op1=%h op2=%h rsp=%h want all 0", div_enable_o,
               div_first_operand_o, div_second_operand_o, rsp_data_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (div_enable_o !== 1'b0 || rsp_valid_o !== 2'b00 || div_first_operand_o !== '0) begin
      bad++;
      $display("FAIL reset_edge: enable=%b rsp_valid=%b op1=%h want 0", div_enable_o,
               rsp_valid_o, div_first_operand_o);
    end
    #1 reset_n = 1'b1;
    m_cv = 1'b0;
    @(posedge clk);
    #2;
    new_ops(0);
    new_ops(1);
    serve(0, 1'b0);
    serve(1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_fast_path();
    test_round_robin();
    test_flush_idle();
    test_flush_issue(10);
    test_flush_issue(N + 4);
    test_flush_resp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative divider instance (`div`) between two requesters, e.g. the execute stage and a coprocessor/accelerator port.
- Arbitrates requests round-robin, latches operands, and sequences the divider's enable/hold protocol.
- Returns either the quotient or the remainder through a valid/ready response channel.
- Holds a one-entry result cache, so that a DIV/REM pair on identical operands needs only one divider run.

Parameters:
- N, 32, operand/result width; must match the attached divider.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  request valid, bit k = requester k
- req_ready_o  out  2  request accepted; one-hot or zero
- req_a_i  in  2*N  dividend; requester k in [k*N +: N]
- req_b_i  in  2*N  divisor, same packing
- req_signed_i  in  2  signed operation
- req_rem_i  in  2  1 = return remainder, 0 = return quotient
- rsp_valid_o  out  2  response valid to requester k; one-hot or zero
- rsp_data_o  out  N  response data, shared by both requesters
- rsp_ready_i  in  2  response accepted by requester k
- flush_i  in  1  drop the outstanding operation and invalidate the cache
- div_first_operand_o  out  N  to divider first_operand_i
- div_second_operand_o  out  N  to divider second_operand_i
- div_signed_o  out  1  to divider signed_i
- div_enable_o  out  1  to divider enable_i
- div_hold_i  in  1  from divider hold_o
- div_result_i  in  N  from divider div_result_o
- rem_result_i  in  N  from divider rem_result_o

Behaviour:
- Reset values: all outputs 0; registered operands 0; cache invalid; round-robin pointer favours requester 0; state IDLE.
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE, grant selection:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not granted last.
  - req_ready_o[grant] = 1 combinationally (accept cycle); the pointer updates on accept.
- IDLE, on accept:
  - Latch a, b, signed, rem and grant id.
  - Cache hit means cache valid and (a, b, signed) equal to the cached values. On a hit, rsp_data is loaded from the cached quotient or remainder and the next state is RESP.
  - On a miss, the next state is ISSUE.
- ISSUE:
  - div_enable_o = 1; operand outputs are driven from registers and stay stable for the whole operation.
  - div_hold_i is high in the first ISSUE cycle because the divider's start is combinational.
  - When div_hold_i == 0 and ISSUE has lasted at least 1 cycle, capture div_result_i and rem_result_i into the cache. Set the cache tag and valid, select rsp_data by rem, and go to RESP.
- RESP:
  - div_enable_o = 0, which clears the divider's valid_result.
  - rsp_valid_o[grant] = 1 and rsp_data_o is held stable until rsp_ready_i[grant]; then go to IDLE.
  - No new request is accepted in the cycle RESP exits.
- Latency from accept cycle t0 to the first rsp_valid cycle:
  - Normal divide: N+5 (37 for N=32).
  - Divide by 0, divide by 1, or signed overflow (divider fast path): 3.
  - Cache hit: 1.
- Flush:
  - Invalidates the cache in every state.
  - In RESP or IDLE: rsp_valid_o drops next cycle and the state goes to IDLE.
  - In ISSUE: go to DRAIN. DRAIN keeps div_enable_o = 1 until div_hold_i == 0, discards the result, leaves the cache invalid, then returns to IDLE with enable 0.
  - Reason for DRAIN: the divider cannot be aborted, and dropping enable mid-run would freeze it.
  - req_ready_o = 0 while flush_i is high.
- A flush coinciding with an ISSUE completion wins: the result is discarded, no response is sent, and the state goes to IDLE.
- Reset mid-operation returns to IDLE immediately. The divider is reset by the same reset_n.
- Reset leaves rsp_valid_o at 0 and the cache invalid.
- A request arriving during ISSUE, RESP or DRAIN is held by its requester and not accepted. The requester must keep valid and its fields stable until ready.

Test Plan:
- Req0 unsigned 100/7, rem=0 -> req_ready_o=01 at t0; rsp_valid_o=01 at t0+37; rsp_data_o=14; held until rsp_ready_i[0].
- Same operands, then rem=1 from req1 -> cache hit; rsp_valid_o=10 at t0+1; rsp_data_o=2; div_enable_o stays 0.
- Signed -7/2 (0xFFFFFFF9/2) then rem -> quotient 0xFFFFFFFD; remainder 0xFFFFFFFF.
- Both requesters valid every cycle, 4 misses -> grants alternate 0,1,0,1 starting with 0 after reset; no starvation.
- b=0, a=5 -> response at t0+3, 0xFFFFFFFF; rem=1 -> 5; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- flush_i pulsed 10 cycles into ISSUE -> DRAIN keeps div_enable_o high until div_hold_i low; no rsp_valid; the next identical request misses the cache and recomputes; reset_n asserted mid-ISSUE -> all outputs 0 next edge.
